// File: rtl/mac12_seq_if.sv
// Handshake and data bundle of the sequential 12x12 MAC stage.
// The requester holds the master modport and the MAC holds the slave modport.
interface mac12_seq_if;
  logic        start;
  logic        clr_acc;
  logic [11:0] A;
  logic [11:0] B;
  logic [23:0] ACC;
  logic        OVF;
  logic        busy;
  logic        done;

  modport master (output start, clr_acc, A, B, input ACC, OVF, busy, done);
  modport slave  (input start, clr_acc, A, B, output ACC, OVF, busy, done);
endinterface

// File: rtl/mac12_seq.sv
// Sequential 12x12 unsigned shift-and-add MAC with a 24-bit accumulator.
// One shared carry-select adder performs both the partial-product adds and the accumulate add.
module csel_blk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] s0, s1;

  // Both carry-in outcomes are formed up front; the incoming carry only selects between them.
  assign s0   = {1'b0, a} + {1'b0, b};
  assign s1   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
  assign sum  = cin ? s1[W-1:0] : s0[W-1:0];
  assign cout = cin ? s1[W] : s0[W];
endmodule

module fa24bit_sc (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        cin,
  output logic [23:0] sum,
  output logic        cout
);
  localparam int BLK  = 4;
  localparam int NBLK = 24 / BLK;

  logic [NBLK:0] c;
  assign c[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    csel_blk #(.W(BLK)) u_blk (
      .a   (a[i*BLK +: BLK]),
      .b   (b[i*BLK +: BLK]),
      .cin (c[i]),
      .sum (sum[i*BLK +: BLK]),
      .cout(c[i+1])
    );
  end

  assign cout = c[NBLK];
endmodule

module mac12_seq (
  input  logic       clk,
  input  logic       reset,
  mac12_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t      state;
  logic [23:0] a_reg;
  logic [11:0] b_reg;
  logic [23:0] prod;
  logic [3:0]  cnt;
  logic [23:0] acc;
  logic        ovf, busy, done;

  logic [23:0] add_a, add_b, sum;
  logic        cout;

  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (state)
      S_MUL: begin
        add_a = prod;
        add_b = b_reg[cnt] ? (a_reg << cnt) : '0;
      end
      S_ACC: begin
        add_a = acc;
        add_b = prod;
      end
      default: ;
    endcase
  end

  fa24bit_sc u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      prod  <= '0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // A clear and a start in the same cycle both apply; the new product lands on zero.
          if (bus.clr_acc) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          if (bus.start) begin
            a_reg <= {12'h000, bus.A};
            b_reg <= bus.B;
            prod  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod <= sum;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd11) state <= S_ACC;
        end
        S_ACC: begin
          acc   <= sum;
          ovf   <= ovf | cout;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ACC  = acc;
  assign bus.OVF  = ovf;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_mac12_seq.sv
// Self-checking bench for mac12_seq: directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic accumulate model.
module tb_mac12_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac12_seq_if bus ();
  mac12_seq dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [23:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        clr;
    int          mode;
    logic [23:0] acc;
    logic        ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // mode 0: idle inputs during busy; 1: random start/clr/A/B while busy; 2: clr_acc held while busy
  task automatic run_op(input string nm, input logic [11:0] a, input logic [11:0] b,
                        input logic clr, input int mode,
                        input logic [23:0] exp_acc, input logic exp_ovf);
    int busy_n, done_at, done_n, both;
    logic [23:0] pre_acc, mid_acc;
    logic        pre_ovf, mid_ovf;
    pre_acc = clr ? 24'h0 : m_acc;
    pre_ovf = clr ? 1'b0 : m_ovf;
    mid_acc = '0;
    mid_ovf = 1'b0;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.start = 1'b1; bus.clr_acc = clr;
    @(posedge clk);
    busy_n = 0; done_at = -1; done_n = 0; both = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 13 && mode == 1) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.clr_acc = 1'($urandom_range(0, 1));
        bus.A       = 12'($urandom);
        bus.B       = 12'($urandom);
      end else begin
        bus.start   = 1'b0;
        bus.clr_acc = (c <= 13 && mode == 2);
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (bus.busy && bus.done) both++;
      if (c == 13) begin
        mid_acc = bus.ACC;
        mid_ovf = bus.OVF;
      end
    end
    chk({nm, " acc"}, 32'(bus.ACC), 32'(exp_acc));
    chk({nm, " ovf"}, 32'(bus.OVF), 32'(exp_ovf));
    chk({nm, " busy cycles"}, 32'(busy_n), 32'd13);
    chk({nm, " done cycle"}, 32'(done_at), 32'd14);
    chk({nm, " done count"}, 32'(done_n), 32'd1);
    chk({nm, " busy&done"}, 32'(both), 32'd0);
    chk({nm, " acc held while busy"}, 32'(mid_acc), 32'(pre_acc));
    chk({nm, " ovf held while busy"}, 32'(mid_ovf), 32'(pre_ovf));
    m_acc = exp_acc;
    m_ovf = exp_ovf;
  endtask

  initial begin
    logic [11:0] ra, rb;
    logic        rc;
    logic [24:0] s;
    logic [23:0] base;
    logic        eovf;

    tbl[0] = '{12'd3,   12'd5,   1'b0, 0, 24'h00000F, 1'b0};
    tbl[1] = '{12'hFFF, 12'hFFF, 1'b1, 0, 24'hFFE001, 1'b0};
    tbl[2] = '{12'hFFF, 12'hFFF, 1'b0, 0, 24'hFFC002, 1'b1};
    tbl[3] = '{12'd1,   12'd1,   1'b0, 0, 24'hFFC003, 1'b1};
    tbl[4] = '{12'd19,  12'd863, 1'b0, 0, 24'h000010, 1'b1};
    tbl[5] = '{12'd4,   12'd4,   1'b1, 0, 24'h000010, 1'b0};
    tbl[6] = '{12'h123, 12'd1,   1'b1, 0, 24'h000123, 1'b0};
    tbl[7] = '{12'd0,   12'h555, 1'b0, 0, 24'h000123, 1'b0};
    tbl[8] = '{12'hABC, 12'd0,   1'b0, 1, 24'h000123, 1'b0};
    tbl[9] = '{12'd10,  12'd10,  1'b0, 2, 24'h000187, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.clr_acc = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset acc", 32'(bus.ACC), 32'h0);
    chk("reset ovf", 32'(bus.OVF), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].mode,
             tbl[i].acc, tbl[i].ovf);

    // Latched operands must win over new A/B driven every busy cycle.
    run_op("wiggle", 12'd100, 12'd200, 1'b0, 1, 24'h000187 + 24'd20000, 1'b0);

    // Reset in the middle of MUL discards the operation.
    @(negedge clk);
    bus.A = 12'hFFF; bus.B = 12'hFFF; bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 6) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 32'(bus.busy), 32'h0);
    chk("midreset done", 32'(bus.done), 32'h0);
    chk("midreset acc", 32'(bus.ACC), 32'h0);
    chk("midreset ovf", 32'(bus.OVF), 32'h0);
    m_acc = '0;
    m_ovf = 1'b0;
    run_op("post reset", 12'd2, 12'd7, 1'b0, 0, 24'h00000E, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? (12'hF00 | 12'($urandom)) : 12'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? (12'hF00 | 12'($urandom)) : 12'($urandom);
      rc = ($urandom_range(0, 7) == 0);
      base = rc ? 24'h0 : m_acc;
      eovf = rc ? 1'b0 : m_ovf;
      s = 25'(base) + 25'(ra) * 25'(rb);
      eovf = eovf | s[24];
      run_op($sformatf("rnd%0d", i), ra, rb, rc, int'($urandom_range(0, 2)), s[23:0], eovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
